// File: rtl/jkseq_pkg.sv
// Shared constants for the JK bank sequencer: opcodes, FSM encodings and default sizes.
// Optional down-count support is selected with JKSEQ_DOWN_EN.
package jkseq_pkg;

   localparam int DEF_WIDTH = 8;
   localparam int DEF_LEN_W = 4;

   localparam logic [2:0] OP_NOP   = 3'b000;
   localparam logic [2:0] OP_CLEAR = 3'b001;
   localparam logic [2:0] OP_SET   = 3'b010;
   localparam logic [2:0] OP_LOAD  = 3'b011;
   localparam logic [2:0] OP_TGL   = 3'b100;
   localparam logic [2:0] OP_UP    = 3'b101;
   localparam logic [2:0] OP_DOWN  = 3'b110;
   localparam logic [2:0] OP_SHL   = 3'b111;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_EXEC = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   // Opcodes that run for len+1 steps; everything else is a single step.
   function automatic logic is_multi(input logic [2:0] op);
`ifdef JKSEQ_DOWN_EN
      return (op == OP_UP) || (op == OP_DOWN) || (op == OP_SHL);
`else
      return (op == OP_UP) || (op == OP_SHL);
`endif
   endfunction

endpackage

// File: rtl/jk_cell.sv
// Single JK storage bit: hold / reset / set / toggle, synchronous active-low reset.
module jk_cell (
   input  logic clk,
   input  logic rst_n,
   input  logic j,
   input  logic k,
   output logic q
);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         q <= 1'b0;
      end else begin
         case ({j, k})
            2'b01:   q <= 1'b0;
            2'b10:   q <= 1'b1;
            2'b11:   q <= ~q;
            default: q <= q;
         endcase
      end
   end

endmodule

// File: rtl/jk_bank_sequencer.sv
// Command-driven J/K sequencer over a WIDTH-bit bank of jk_cell instances.
// Down-counting (opcode 110) exists only when JKSEQ_DOWN_EN is defined.
//
// state   | meaning
// IDLE    | ready for a command; cells hold
// EXEC    | one J/K step per cycle, step counter counts down to 0
// DONE    | one-cycle completion pulse, then back to IDLE
module jk_bank_sequencer
   import jkseq_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int LEN_W = DEF_LEN_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [2:0]       cmd_op,
   input  logic [WIDTH-1:0] cmd_data,
   input  logic [LEN_W-1:0] cmd_len,
   output logic [WIDTH-1:0] q,
   output logic             busy,
   output logic             done,
   output logic             wrap
);

   logic [1:0]       state;
   logic [2:0]       op_r;
   logic [WIDTH-1:0] data_r;
   logic [LEN_W-1:0] cnt;
   logic [WIDTH-1:0] j;
   logic [WIDTH-1:0] k;
   logic [WIDTH-1:0] up_t;
   logic [WIDTH-1:0] shl_src;
   logic             wrap_nxt;
`ifdef JKSEQ_DOWN_EN
   logic [WIDTH-1:0] dn_t;
`endif

   assign cmd_ready = (state == ST_IDLE);
   assign busy      = (state == ST_EXEC) || (state == ST_DONE);
   assign done      = (state == ST_DONE);
   assign shl_src   = {q[WIDTH-2:0], data_r[0]};

   // Toggle enables: bit i flips when every lower bit is 1 (up) or 0 (down).
   always_comb begin
      logic acc_up;
      acc_up = 1'b1;
      up_t   = '0;
      for (int i = 0; i < WIDTH; i++) begin
         up_t[i] = acc_up;
         acc_up  = acc_up & q[i];
      end
   end

`ifdef JKSEQ_DOWN_EN
   always_comb begin
      logic acc_dn;
      acc_dn = 1'b1;
      dn_t   = '0;
      for (int i = 0; i < WIDTH; i++) begin
         dn_t[i] = acc_dn;
         acc_dn  = acc_dn & ~q[i];
      end
   end
`endif

   always_comb begin
      j = '0;
      k = '0;
      if (state == ST_EXEC) begin
         case (op_r)
            OP_CLEAR: k = '1;
            OP_SET:   j = '1;
            OP_LOAD: begin
               j = data_r;
               k = ~data_r;
            end
            OP_TGL: begin
               j = data_r;
               k = data_r;
            end
            OP_UP: begin
               j = up_t;
               k = up_t;
            end
`ifdef JKSEQ_DOWN_EN
            OP_DOWN: begin
               j = dn_t;
               k = dn_t;
            end
`endif
            OP_SHL: begin
               j = shl_src;
               k = ~shl_src;
            end
            default: begin
               j = '0;
               k = '0;
            end
         endcase
      end
   end

   always_comb begin
      wrap_nxt = 1'b0;
      if (state == ST_EXEC) begin
         if ((op_r == OP_UP) && (&q)) wrap_nxt = 1'b1;
`ifdef JKSEQ_DOWN_EN
         if ((op_r == OP_DOWN) && !(|q)) wrap_nxt = 1'b1;
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state  <= ST_IDLE;
         op_r   <= OP_NOP;
         data_r <= '0;
         cnt    <= '0;
         wrap   <= 1'b0;
      end else begin
         wrap <= wrap_nxt;
         case (state)
            ST_IDLE: begin
               if (cmd_valid) begin
                  state  <= ST_EXEC;
                  op_r   <= cmd_op;
                  data_r <= cmd_data;
                  cnt    <= is_multi(cmd_op) ? cmd_len : '0;
               end
            end
            ST_EXEC: begin
               if (cnt == '0) state <= ST_DONE;
               else           cnt   <= cnt - 1'b1;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
      jk_cell u_cell (
         .clk   (clk),
         .rst_n (rst_n),
         .j     (j[gi]),
         .k     (k[gi]),
         .q     (q[gi])
      );
   end

endmodule
